// File: rtl/ddf_pkg.sv
// Shared types and fold arithmetic for the round-robin dataflow accumulator.
// DDF_SATURATE_EN: when defined, OP_SUM clamps at the all-ones value instead of wrapping.
package ddf_pkg;

  typedef enum logic [1:0] {
    PICK   = 2'd0,
    ACTION = 2'd1,
    HOLD   = 2'd2
  } flux_state_t;

  localparam int OP_SUM = 0;
  localparam int OP_MAX = 1;
  localparam int OP_MIN = 2;

  // Arithmetic is done on a fixed-width word; payloads up to 32 bits are supported.
  localparam int MAX_DW = 32;
  typedef logic [MAX_DW-1:0] word_t;

  function automatic word_t width_mask(int dw);
    logic [63:0] m;
    m = (64'd1 << dw) - 64'd1;
    return (dw >= MAX_DW) ? '1 : m[MAX_DW-1:0];
  endfunction

  function automatic word_t init_val(int op, int dw);
    return (op == OP_MIN) ? width_mask(dw) : '0;
  endfunction

  function automatic word_t fold(word_t a, word_t b, int op, int dw);
    word_t           m;
    word_t           am;
    word_t           bm;
    logic [MAX_DW:0] sum;
    m   = width_mask(dw);
    am  = a & m;
    bm  = b & m;
    sum = {1'b0, am} + {1'b0, bm};
    case (op)
      OP_MAX:  fold = (am > bm) ? am : bm;
      OP_MIN:  fold = (am < bm) ? am : bm;
      default: begin
`ifdef DDF_SATURATE_EN
        fold = (sum > {1'b0, m}) ? m : sum[MAX_DW-1:0];
`else
        fold = sum[MAX_DW-1:0] & m;
`endif
      end
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant of one requester per cycle; search starts at ptr, which
// advances past the winner only when a grant is issued.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;
  int            j;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    gnt_valid = en && found;
    ptr_d     = ptr_q;
    if (gnt_valid) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ddf_rr_acc.sv
// Multi-flux accumulator actor: per flux, read a count, fold that many token sets,
// emit {tag, acc}. Build option DDF_SATURATE_EN selects clamping sums.
module ddf_rr_acc
  import ddf_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int FLUX       = 2,
  parameter  int PORTS      = 2,
  parameter  int OP         = 0,
  localparam int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1,
  localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [WIDTH-1:0]        write_din,
  output logic                    write_write,
  input  logic                    write_full,
  input  logic [WIDTH*PORTS-1:0]  read_dout,
  input  logic [PORTS*FLUX-1:0]   read_empty,
  output logic [PORTS*FLUX-1:0]   read_read,
  input  logic [WIDTH-1:0]        nda_dout,
  input  logic [FLUX-1:0]         nda_empty,
  output logic [FLUX-1:0]         nda_read
);

  localparam logic [DATA_WIDTH-1:0] INIT = DATA_WIDTH'(init_val(OP, DATA_WIDTH));

  flux_state_t           state_q [FLUX];
  flux_state_t           state_d [FLUX];
  logic [DATA_WIDTH-1:0] cnt_q   [FLUX];
  logic [DATA_WIDTH-1:0] cnt_d   [FLUX];
  logic [DATA_WIDTH-1:0] acc_q   [FLUX];
  logic [DATA_WIDTH-1:0] acc_d   [FLUX];

  logic [FLUX-1:0]       req;
  logic                  gnt_valid;
  logic [TAG_WIDTH-1:0]  gnt_idx;
  logic [DATA_WIDTH-1:0] nda_n;
  word_t                 x_w;
  word_t                 r_w;
  logic                  unused_bits;

  assign nda_n       = nda_dout[DATA_WIDTH-1:0];
  assign unused_bits = ^{nda_dout, read_dout, r_w, x_w};

  for (genvar gi = 0; gi < FLUX; gi++) begin : g_req
    assign req[gi] = (state_q[gi] == PICK   && !nda_empty[gi]) ||
                     (state_q[gi] == ACTION && read_empty[gi*PORTS +: PORTS] == '0) ||
                     (state_q[gi] == HOLD   && !write_full);
  end

  // Holding the arbiter disabled in reset keeps every strobe low while rst is high.
  rr_arbiter #(.N(FLUX)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .en        (!rst),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    nda_read    = '0;
    read_read   = '0;
    write_write = 1'b0;
    write_din   = '0;
    r_w         = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;

    // Token payloads share one bus across fluxes, so the port fold is computed once.
    x_w = word_t'(read_dout[DATA_WIDTH-1:0]);
    for (int p = 1; p < PORTS; p++)
      x_w = fold(x_w, word_t'(read_dout[p*WIDTH +: DATA_WIDTH]), OP, DATA_WIDTH);

    for (int f = 0; f < FLUX; f++) begin
      if (gnt_valid && int'(gnt_idx) == f) begin
        r_w = fold(word_t'(acc_q[f]), x_w, OP, DATA_WIDTH);
        case (state_q[f])
          PICK: begin
            nda_read[f] = 1'b1;
            cnt_d[f]    = (nda_n == '0) ? '0 : nda_n - 1'b1;
            acc_d[f]    = INIT;
            state_d[f]  = ACTION;
          end
          ACTION: begin
            read_read[f*PORTS +: PORTS] = '1;
            if (cnt_q[f] != '0) begin
              acc_d[f] = r_w[DATA_WIDTH-1:0];
              cnt_d[f] = cnt_q[f] - 1'b1;
            end else if (!write_full) begin
              write_write = 1'b1;
              write_din   = {TAG_WIDTH'(f), r_w[DATA_WIDTH-1:0]};
              acc_d[f]    = INIT;
              state_d[f]  = PICK;
            end else begin
              acc_d[f]   = r_w[DATA_WIDTH-1:0];
              state_d[f] = HOLD;
            end
          end
          HOLD: begin
            write_write = 1'b1;
            write_din   = {TAG_WIDTH'(f), acc_q[f]};
            acc_d[f]    = INIT;
            state_d[f]  = PICK;
          end
          default: state_d[f] = PICK;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int f = 0; f < FLUX; f++) begin
      if (rst) begin
        state_q[f] <= PICK;
        cnt_q[f]   <= '0;
        acc_q[f]   <= INIT;
      end else begin
        state_q[f] <= state_d[f];
        cnt_q[f]   <= cnt_d[f];
        acc_q[f]   <= acc_d[f];
      end
    end
  end

endmodule

// File: tb/tb_ddf_rr_acc.sv
// Bench: three accumulators (sum/max/min) on shared stimulus, checked cycle by
// cycle against an arithmetic reference model, plus directed scenario checks.
module tb_ddf_rr_acc;

  localparam int DW = 8;
  localparam int FX = 2;
  localparam int PT = 2;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  nda_dout;
  logic [FX-1:0] nda_empty;
  logic [W*PT-1:0] rd_dout;
  logic [PT*FX-1:0] rd_empty;
  logic          full;

  logic [FX-1:0]    o_nda [3];
  logic [PT*FX-1:0] o_rd  [3];
  logic             o_wr  [3];
  logic [W-1:0]     o_din [3];

  logic [FX-1:0]    cap_nda [3];
  logic [PT*FX-1:0] cap_rd  [3];
  logic             cap_wr  [3];
  logic [W-1:0]     cap_din [3];
  int               cap_g;

  int total;
  int bad;

  int m_state [FX];
  int m_cnt   [FX];
  int m_acc   [3][FX];
  int m_ptr;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    ddf_rr_acc #(.DATA_WIDTH(DW), .FLUX(FX), .PORTS(PT), .OP(k)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .write_din   (o_din[k]),
      .write_write (o_wr[k]),
      .write_full  (full),
      .read_dout   (rd_dout),
      .read_empty  (rd_empty),
      .read_read   (o_rd[k]),
      .nda_dout    (nda_dout),
      .nda_empty   (nda_empty),
      .nda_read    (o_nda[k])
    );
  end

  function automatic int ref_fold(int op, int a, int b);
    if (op == 1) return (a > b) ? a : b;
    if (op == 2) return (a < b) ? a : b;
`ifdef DDF_SATURATE_EN
    return (a + b > 255) ? 255 : a + b;
`else
    return (a + b) % 256;
`endif
  endfunction

  function automatic int ref_init(int op);
    return (op == 2) ? 255 : 0;
  endfunction

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s op=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < FX; f++) begin
      m_state[f] = 0;
      m_cnt[f]   = 0;
      for (int k = 0; k < 3; k++) m_acc[k][f] = ref_init(k);
    end
    m_ptr = 0;
  endtask

  task automatic set_pair(int p0, int p1);
    rd_dout = {1'b1, 8'(p1), 1'b1, 8'(p0)};
  endtask

  // One clock: compare this cycle's outputs with the model, then advance to the next cycle.
  task automatic step();
    int g, n, d0, d1, x, r, fi;
    int e_nda, e_rd;
    int e_wr  [3];
    int e_din [3];
    bool_dummy();
    #1;
    e_nda = 0; e_rd = 0; g = -1;
    for (int k = 0; k < 3; k++) begin e_wr[k] = 0; e_din[k] = 0; end
    if (!rst) begin
      for (int i = 0; i < FX; i++) begin
        fi = (m_ptr + i) % FX;
        if (g < 0 && ((m_state[fi] == 0 && !nda_empty[fi]) ||
                      (m_state[fi] == 1 && rd_empty[fi*PT +: PT] == '0) ||
                      (m_state[fi] == 2 && !full)))
          g = fi;
      end
    end
    if (g >= 0) begin
      d0 = int'(rd_dout[DW-1:0]);
      d1 = int'(rd_dout[W +: DW]);
      if (m_state[g] == 0) begin
        e_nda = 1 << g;
        n = int'(nda_dout[DW-1:0]);
        m_cnt[g] = (n == 0) ? 0 : n - 1;
        for (int k = 0; k < 3; k++) m_acc[k][g] = ref_init(k);
        m_state[g] = 1;
      end else if (m_state[g] == 1) begin
        e_rd = 3 << (PT * g);
        for (int k = 0; k < 3; k++) begin
          x = ref_fold(k, d0, d1);
          r = ref_fold(k, m_acc[k][g], x);
          if (m_cnt[g] == 0 && !full) begin
            e_wr[k] = 1; e_din[k] = g * 256 + r; m_acc[k][g] = ref_init(k);
          end else begin
            m_acc[k][g] = r;
          end
        end
        if (m_cnt[g] > 0)  m_cnt[g]--;
        else if (!full)    m_state[g] = 0;
        else               m_state[g] = 2;
      end else begin
        for (int k = 0; k < 3; k++) begin
          e_wr[k] = 1; e_din[k] = g * 256 + m_acc[k][g]; m_acc[k][g] = ref_init(k);
        end
        m_state[g] = 0;
      end
      m_ptr = (g + 1) % FX;
    end
    for (int k = 0; k < 3; k++) begin
      cap_nda[k] = o_nda[k]; cap_rd[k] = o_rd[k]; cap_wr[k] = o_wr[k]; cap_din[k] = o_din[k];
      chk("nda_read", k, 32'(o_nda[k]), 32'(e_nda));
      chk("read",     k, 32'(o_rd[k]),  32'(e_rd));
      chk("write",    k, 32'(o_wr[k]),  32'(e_wr[k]));
      chk("din",      k, 32'(o_din[k]), 32'(e_din[k]));
    end
    if (cap_nda[0][0] || cap_rd[0][1:0] != 2'b00 || (cap_wr[0] && !cap_din[0][DW])) cap_g = 0;
    else if (cap_nda[0][1] || cap_rd[0][3:2] != 2'b00 || (cap_wr[0] && cap_din[0][DW])) cap_g = 1;
    else cap_g = -1;
    $display("cyc rst=%0b grant=%0d wr=%0b din_sum=%03h din_max=%03h din_min=%03h",
             rst, g, o_wr[0], o_din[0], o_din[1], o_din[2]);
    if (rst) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic bool_dummy();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; nda_empty = '1; nda_dout = '0; rd_empty = '1; rd_dout = '0; full = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Everything eligible during reset: outputs must stay quiet.
    nda_empty = '0; rd_empty = '0; nda_dout = 9'd5; rd_dout = 18'h2a5c3;
    repeat (2) begin
      step();
      chk("rst_wr",  0, 32'(cap_wr[0]),  32'd0);
      chk("rst_nda", 0, 32'(cap_nda[0]), 32'd0);
    end
    rst = 1'b0; nda_empty = '1; rd_empty = '1;

    // flux0, N=3: (1,2) (3,4) (5,6) -> {0,21}
    nda_empty = 2'b10; nda_dout = 9'd3; step();
    chk("t1_pick", 0, 32'(cap_nda[0]), 32'd1);
    nda_empty = 2'b11; rd_empty = 4'b1100;
    set_pair(1, 2); step(); chk("t1_nowr_a", 0, 32'(cap_wr[0]), 32'd0);
    set_pair(3, 4); step(); chk("t1_nowr_b", 0, 32'(cap_wr[0]), 32'd0);
    set_pair(5, 6); step();
    chk("t1_wr",  0, 32'(cap_wr[0]),  32'd1);
    chk("t1_din", 0, 32'(cap_din[0]), 32'd21);
    rd_empty = 4'b1111; step(); chk("t1_idle", 0, 32'(cap_wr[0]), 32'd0);

    // flux1, N=0 treated as 1: (7,8) -> {1,15}
    nda_empty = 2'b01; nda_dout = 9'h100; step();
    chk("t2_pick", 0, 32'(cap_nda[0]), 32'd2);
    nda_empty = 2'b11; rd_empty = 4'b0011; set_pair(7, 8); step();
    chk("t2_wr",  0, 32'(cap_wr[0]),  32'd1);
    chk("t2_din", 0, 32'(cap_din[0]), 32'h10f);
    rd_empty = 4'b1111;

    // Both fluxes always eligible: grants alternate starting from flux0.
    nda_empty = 2'b00; nda_dout = 9'd2; rd_empty = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      rd_dout = 18'($urandom);
      step();
      chk("rr_seq", 0, 32'(cap_g), 32'(i % 2));
    end

    // full on the last operation: inputs consumed, result held until full drops.
    nda_empty = 2'b10; rd_empty = 4'b1111; step();
    nda_empty = 2'b11; rd_empty = 4'b1100;
    set_pair(10, 20); step();
    set_pair(30, 40); full = 1'b1; step();
    chk("t4_rd",   0, 32'(cap_rd[0]), 32'd3);
    chk("t4_nowr", 0, 32'(cap_wr[0]), 32'd0);
    rd_empty = 4'b1111;
    repeat (3) begin step(); chk("t4_hold", 0, 32'(cap_wr[0]), 32'd0); end
    full = 1'b0; step();
    chk("t4_wr",  0, 32'(cap_wr[0]),  32'd1);
    chk("t4_din", 0, 32'(cap_din[0]), 32'd100);
    nda_empty = 2'b10; nda_dout = 9'd1; step();
    chk("t4_pick", 0, 32'(cap_nda[0]), 32'd1);

    // flux1, N=2: (9,4) (6,12) -> sum 31, max 12, min 4
    nda_empty = 2'b01; nda_dout = 9'd2; step();
    nda_empty = 2'b11; rd_empty = 4'b0011;
    set_pair(9, 4); step();
    set_pair(6, 12); step();
    chk("t5_sum", 0, 32'(cap_din[0]), 32'h11f);
    chk("t5_max", 1, 32'(cap_din[1]), 32'h10c);
    chk("t5_min", 2, 32'(cap_din[2]), 32'h104);
    rd_empty = 4'b1111;

    // flux1, N=2: (200,100) (50,10) -> wrap 104 / clamp 255
    nda_empty = 2'b01; nda_dout = 9'd2; step();
    nda_empty = 2'b11; rd_empty = 4'b0011;
    set_pair(200, 100); step();
    set_pair(50, 10); step();
`ifdef DDF_SATURATE_EN
    chk("t6_sum", 0, 32'(cap_din[0]), 32'h1ff);
`else
    chk("t6_sum", 0, 32'(cap_din[0]), 32'h168);
`endif
    chk("t6_max", 1, 32'(cap_din[1]), 32'h1c8);
    chk("t6_min", 2, 32'(cap_din[2]), 32'h10a);
    rd_empty = 4'b1111;

    // Reset mid-count discards the partial sum.
    nda_empty = 2'b01; nda_dout = 9'd3; step();
    nda_empty = 2'b11; rd_empty = 4'b0011; set_pair(100, 100); step();
    rst = 1'b1; rd_empty = 4'b1111; step();
    rst = 1'b0; nda_empty = 2'b01; nda_dout = 9'd1; step();
    nda_empty = 2'b11; rd_empty = 4'b0011; set_pair(1, 1); step();
    chk("t7_wr",  0, 32'(cap_wr[0]),  32'd1);
    chk("t7_din", 0, 32'(cap_din[0]), 32'h102);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      nda_empty = 2'($urandom);
      nda_dout  = {1'($urandom), 8'($urandom_range(0, 4))};
      rd_dout   = 18'($urandom);
      for (int b = 0; b < PT * FX; b++) rd_empty[b] = ($urandom_range(0, 2) == 0);
      full      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
